// File: rtl/alu_seq.sv
// Registered valid/ready ALU with a multi-cycle shift-add multiplier.
// Optional build macro ALU_SAT_EN: saturate add/sub/mul results instead of wrapping.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovr,
    output logic             neg
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_result;
    logic                   r_ovr;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_a_ext;
    logic [WIDTH-1:0]       r_b_shift;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_cnt;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH-1:0]       w_alu_result;
    logic                   w_alu_ovr;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic                   w_mul_hi_nz;
    logic [WIDTH-1:0]       w_mul_result;
    logic                   w_mul_last;

    // Single-cycle operations, evaluated on the live inputs for the accept edge
    always_comb begin
        w_sum        = {1'b0, a} + {1'b0, b};
        w_diff       = {1'b0, a} - {1'b0, b};
        w_alu_result = ALL_ZERO;
        w_alu_ovr    = 1'b0;
        case (alu_instr)
            OP_ADD: begin
                w_alu_ovr = w_sum[WIDTH];
`ifdef ALU_SAT_EN
                w_alu_result = w_sum[WIDTH] ? ALL_ONE : w_sum[WIDTH-1:0];
`else
                w_alu_result = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                w_alu_ovr = w_diff[WIDTH];
`ifdef ALU_SAT_EN
                w_alu_result = w_diff[WIDTH] ? ALL_ZERO : w_diff[WIDTH-1:0];
`else
                w_alu_result = w_diff[WIDTH-1:0];
`endif
            end
            OP_AND:  w_alu_result = a & b;
            OP_OR:   w_alu_result = a | b;
            OP_SLT:  w_alu_result = (a < b) ? ONE_W : ALL_ZERO;
            OP_EQ:   w_alu_result = (a == b) ? ONE_W : ALL_ZERO;
            OP_XOR:  w_alu_result = a ^ b;
            default: begin
                w_alu_result = ALL_ZERO;
                w_alu_ovr    = 1'b0;
            end
        endcase
    end

    // Shift-add step; the final iteration's sum feeds the result directly
    always_comb begin
        w_acc_next  = r_b_shift[0] ? (r_acc + r_a_ext) : r_acc;
        w_mul_last  = (r_cnt == CNT_LAST);
        w_mul_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
`ifdef ALU_SAT_EN
        w_mul_result = w_mul_hi_nz ? ALL_ONE : w_acc_next[WIDTH-1:0];
`else
        w_mul_result = w_acc_next[WIDTH-1:0];
`endif
    end

    // Control FSM with registered handshake outputs, result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_result    <= ALL_ZERO;
            r_ovr       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a_ext     <= {(2*WIDTH){1'b0}};
            r_b_shift   <= ALL_ZERO;
            r_acc       <= {(2*WIDTH){1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (alu_instr == OP_MUL) begin
                            r_a_ext   <= {ALL_ZERO, a};
                            r_b_shift <= b;
                            r_acc     <= {(2*WIDTH){1'b0}};
                            r_cnt     <= {CNT_W{1'b0}};
                            r_state   <= MUL;
                        end else begin
                            r_result    <= w_alu_result;
                            r_ovr       <= w_alu_ovr;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    r_acc     <= w_acc_next;
                    r_a_ext   <= r_a_ext << 1;
                    r_b_shift <= r_b_shift >> 1;
                    r_cnt     <= r_cnt + CNT_ONE;
                    if (w_mul_last) begin
                        r_result    <= w_mul_result;
                        r_ovr       <= w_mul_hi_nz;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= MUL;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ovr       = r_ovr;
    assign zero      = (r_result == ALL_ZERO);
    assign neg       = r_result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); honours ALU_SAT_EN.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] alu_instr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       ovr;
    logic       neg;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_instr (alu_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovr       (ovr),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one op at a negedge, scramble operands after accept, measure latency
    task automatic do_op(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         input string tag, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        alu_instr = op;
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        a         = ~ia;
        b         = ~ib;
        alu_instr = 3'b000;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] er, input logic eo,
                              input logic ez, input logic en);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_ovr"},    32'(ovr),    32'(eo));
        check({tag, "_zero"},   32'(zero),   32'(ez));
        check({tag, "_neg"},    32'(neg),    32'(en));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit emitted;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        alu_instr = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        expect_out("rst", 8'd0, 1'b0, 1'b1, 1'b0);

        do_op(3'b000, 8'd200, 8'd100, "add", 1);
`ifdef ALU_SAT_EN
        expect_out("add", 8'd255, 1'b1, 1'b0, 1'b1);
`else
        expect_out("add", 8'd44, 1'b1, 1'b0, 1'b0);
`endif
        take("add");

        do_op(3'b001, 8'd5, 8'd7, "sub", 1);
`ifdef ALU_SAT_EN
        expect_out("sub", 8'd0, 1'b1, 1'b1, 1'b0);
`else
        expect_out("sub", 8'd254, 1'b1, 1'b0, 1'b1);
`endif
        take("sub");

        do_op(3'b110, 8'd15, 8'd17, "mul1", 9);
        expect_out("mul1", 8'd255, 1'b0, 1'b0, 1'b1);
        take("mul1");

        do_op(3'b110, 8'd16, 8'd16, "mul2", 9);
`ifdef ALU_SAT_EN
        expect_out("mul2", 8'd255, 1'b1, 1'b0, 1'b1);
`else
        expect_out("mul2", 8'd0, 1'b1, 1'b1, 1'b0);
`endif
        take("mul2");

        do_op(3'b010, 8'hCA, 8'h0F, "and", 1);
        expect_out("and", 8'h0A, 1'b0, 1'b0, 1'b0);
        take("and");

        do_op(3'b011, 8'hA0, 8'h05, "or", 1);
        expect_out("or", 8'hA5, 1'b0, 1'b0, 1'b1);
        take("or");

        do_op(3'b101, 8'd77, 8'd77, "eq", 1);
        expect_out("eq", 8'd1, 1'b0, 1'b0, 1'b0);
        take("eq");

        // Backpressure: hold the xor result while a second op is offered
        do_op(3'b111, 8'hF0, 8'h3C, "xor", 1);
        alu_instr = 3'b000;
        a         = 8'd1;
        b         = 8'd2;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_result", 32'(result), 32'hCC);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_handshake_valid", 32'(out_valid), 32'd0);
        check("bp_handshake_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        expect_out("bp_second", 8'd3, 1'b0, 1'b0, 1'b0);
        take("bp_second");

        // Reset during multiply iteration 3 must abort silently
        alu_instr = 3'b110;
        a         = 8'd3;
        b         = 8'd5;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        emitted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) emitted = 1'b1;
            @(negedge clk);
        end
        check("abort_no_emit", 32'(emitted), 32'd0);

        do_op(3'b100, 8'd3, 8'd9, "slt", 1);
        expect_out("slt", 8'd1, 1'b0, 1'b0, 1'b0);
        take("slt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
